// File: rtl/vga_timing_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_ctrl
// Description : VGA raster timing, pixel request handshake and aligned
//               one-stage colour/sync output registers.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_ctrl #(
    parameter int   frontporch_h = 16,
    parameter int   sync_h       = 96,
    parameter int   backporch_h  = 48,
    parameter int   active_h     = 640,
    parameter int   frontporch_v = 10,
    parameter int   sync_v       = 2,
    parameter int   backporch_v  = 33,
    parameter int   active_v     = 480,
    parameter logic hsync_pol    = 1'b0,
    parameter logic vsync_pol    = 1'b0,
    parameter int   cnt_w        = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic             pix_req,
    input  logic             pix_rdy,
    input  logic             pix_r,
    input  logic             pix_g,
    input  logic             pix_b,
    output logic [cnt_w-1:0] x,
    output logic [cnt_w-1:0] y,
    output logic             line_start,
    output logic             frame_start,
    output logic             hsync,
    output logic             vsync,
    output logic             r,
    output logic             g,
    output logic             b,
    output logic             underflow,
    input  logic             underflow_clr
);

    localparam int c_h_tot = active_h + frontporch_h + sync_h + backporch_h;
    localparam int c_v_tot = active_v + frontporch_v + sync_v + backporch_v;

    // Last count of each phase; the phase FSMs step when these are reached.
    localparam logic [cnt_w-1:0] c_h_act_end  = cnt_w'(active_h - 1);
    localparam logic [cnt_w-1:0] c_h_fp_end   = cnt_w'(active_h + frontporch_h - 1);
    localparam logic [cnt_w-1:0] c_h_sync_end = cnt_w'(active_h + frontporch_h + sync_h - 1);
    localparam logic [cnt_w-1:0] c_h_last     = cnt_w'(c_h_tot - 1);
    localparam logic [cnt_w-1:0] c_v_act_end  = cnt_w'(active_v - 1);
    localparam logic [cnt_w-1:0] c_v_fp_end   = cnt_w'(active_v + frontporch_v - 1);
    localparam logic [cnt_w-1:0] c_v_sync_end = cnt_w'(active_v + frontporch_v + sync_v - 1);
    localparam logic [cnt_w-1:0] c_v_last     = cnt_w'(c_v_tot - 1);
    localparam logic [cnt_w-1:0] c_h_active   = cnt_w'(active_h);
    localparam logic [cnt_w-1:0] c_v_active   = cnt_w'(active_v);
    localparam logic [cnt_w-1:0] c_one        = cnt_w'(1);

    localparam logic [1:0] c_ph_active = 2'd0;
    localparam logic [1:0] c_ph_front  = 2'd1;
    localparam logic [1:0] c_ph_sync   = 2'd2;
    localparam logic [1:0] c_ph_back   = 2'd3;

    logic [cnt_w-1:0] r_hcnt;
    logic [cnt_w-1:0] r_vcnt;
    logic [1:0]       r_hphase;
    logic [1:0]       r_vphase;
    logic             r_hsync;
    logic             r_vsync;
    logic [2:0]       r_rgb;
    logic             r_underflow;

    logic w_hwrap;
    logic w_vwrap;
    logic w_de0;
    logic w_req;

    assign w_hwrap = (r_hcnt == c_h_last);
    assign w_vwrap = (r_vcnt == c_v_last);
    assign w_de0   = (r_hcnt < c_h_active) && (r_vcnt < c_v_active);
    assign w_req   = w_de0 & en;

    // Horizontal counter and phase
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hcnt   <= '0;
            r_hphase <= c_ph_active;
        end else if (en) begin
            r_hcnt <= w_hwrap ? '0 : r_hcnt + c_one;
            case (r_hphase)
                c_ph_active: if (r_hcnt == c_h_act_end)  r_hphase <= c_ph_front;
                c_ph_front:  if (r_hcnt == c_h_fp_end)   r_hphase <= c_ph_sync;
                c_ph_sync:   if (r_hcnt == c_h_sync_end) r_hphase <= c_ph_back;
                c_ph_back:   if (w_hwrap)                r_hphase <= c_ph_active;
                default:                                 r_hphase <= c_ph_active;
            endcase
        end
    end

    // Vertical counter and phase advance once per completed line
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vcnt   <= '0;
            r_vphase <= c_ph_active;
        end else if (en && w_hwrap) begin
            r_vcnt <= w_vwrap ? '0 : r_vcnt + c_one;
            case (r_vphase)
                c_ph_active: if (r_vcnt == c_v_act_end)  r_vphase <= c_ph_front;
                c_ph_front:  if (r_vcnt == c_v_fp_end)   r_vphase <= c_ph_sync;
                c_ph_sync:   if (r_vcnt == c_v_sync_end) r_vphase <= c_ph_back;
                c_ph_back:   if (w_vwrap)                r_vphase <= c_ph_active;
                default:                                 r_vphase <= c_ph_active;
            endcase
        end
    end

    // Output stage: sync and colour share the same one-tick latency
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hsync <= ~hsync_pol;
            r_vsync <= ~vsync_pol;
            r_rgb   <= 3'b000;
        end else if (en) begin
            r_hsync <= (r_hphase == c_ph_sync) ? hsync_pol : ~hsync_pol;
            r_vsync <= (r_vphase == c_ph_sync) ? vsync_pol : ~vsync_pol;
            r_rgb   <= (w_de0 & pix_rdy) ? {pix_r, pix_g, pix_b} : 3'b000;
        end
    end

    // Sticky underflow; a new miss outranks a clear in the same cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_underflow <= 1'b0;
        end else if (w_req && !pix_rdy) begin
            r_underflow <= 1'b1;
        end else if (underflow_clr) begin
            r_underflow <= 1'b0;
        end
    end

    assign pix_req     = w_req;
    assign x           = r_hcnt;
    assign y           = r_vcnt;
    assign line_start  = (r_hcnt == '0) & en;
    assign frame_start = (r_hcnt == '0) & (r_vcnt == '0) & en;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign r           = r_rgb[2];
    assign g           = r_rgb[1];
    assign b           = r_rgb[0];
    assign underflow   = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_timing_ctrl
// Description : Scoreboard bench for vga_timing_ctrl on a shrunken raster.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_ctrl;

    localparam int AH = 8, FH = 2, SH = 3, BH = 3;
    localparam int AV = 4, FV = 1, SV = 2, BV = 2;
    localparam int CW = 6;
    localparam int HT = AH + FH + SH + BH;
    localparam int VT = AV + FV + SV + BV;
    localparam logic HPOL = 1'b1;
    localparam logic VPOL = 1'b0;

    logic clk;
    logic rst, en, pix_rdy, pix_r, pix_g, pix_b, underflow_clr;
    logic pix_req, line_start, frame_start, hsync, vsync, r, g, b, underflow;
    logic [CW-1:0] x, y;

    vga_timing_ctrl #(
        .frontporch_h(FH), .sync_h(SH), .backporch_h(BH), .active_h(AH),
        .frontporch_v(FV), .sync_v(SV), .backporch_v(BV), .active_v(AV),
        .hsync_pol(HPOL), .vsync_pol(VPOL), .cnt_w(CW)
    ) dut (
        .clk(clk), .rst(rst), .en(en),
        .pix_req(pix_req), .pix_rdy(pix_rdy),
        .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
        .x(x), .y(y), .line_start(line_start), .frame_start(frame_start),
        .hsync(hsync), .vsync(vsync), .r(r), .g(g), .b(b),
        .underflow(underflow), .underflow_clr(underflow_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic          preq;
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        logic          ls;
        logic          fs;
    } comb_t;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic [2:0] rgb;
        logic       uf;
    } regs_t;

    typedef struct packed {
        comb_t c;
        regs_t r;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   pushed   = 0;
    int   popped   = 0;

    // Reference model: raster position as a single pixel index within the frame
    int         m_pos;
    logic       m_hs, m_vs, m_uf;
    logic [2:0] m_rgb;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_pos = 0;
        m_hs  = ~HPOL;
        m_vs  = ~VPOL;
        m_rgb = 3'b000;
        m_uf  = 1'b0;
    endtask

    task automatic step(input logic e, input logic rdy, input logic [2:0] col, input logic clr);
        int   h, v;
        logic de;
        exp_t ex;
        @(negedge clk);
        en = e;
        pix_rdy = rdy;
        {pix_r, pix_g, pix_b} = col;
        underflow_clr = clr;
        h  = m_pos % HT;
        v  = m_pos / HT;
        de = (h < AH) && (v < AV);
        ex.c.preq = de & e;
        ex.c.x    = CW'(h);
        ex.c.y    = CW'(v);
        ex.c.ls   = (h == 0) & e;
        ex.c.fs   = (m_pos == 0) & e;
        if (e) begin
            m_hs  = (h >= AH + FH && h < AH + FH + SH) ? HPOL : ~HPOL;
            m_vs  = (v >= AV + FV && v < AV + FV + SV) ? VPOL : ~VPOL;
            m_rgb = (de && rdy) ? col : 3'b000;
            m_pos = (m_pos + 1) % (HT * VT);
        end
        if (de && e && !rdy) m_uf = 1'b1;
        else if (clr)        m_uf = 1'b0;
        ex.r = {m_hs, m_vs, m_rgb, m_uf};
        q.push_back(ex);
        pushed++;
    endtask

    task automatic rand_step();
        step(($urandom_range(3) != 0), ($urandom_range(9) != 0),
             3'($urandom_range(7)), ($urandom_range(9) == 0));
    endtask

    // Asynchronous reset asserted between clock edges, held across en ticks
    task automatic do_reset(input int cycles);
        @(negedge clk);
        rst = 1'b1;
        en = 1'b1;
        pix_rdy = 1'b1;
        {pix_r, pix_g, pix_b} = 3'b111;
        underflow_clr = 1'b0;
        #1;
        check("rst_xy", {x, y}, '0);
        check("rst_regs", {hsync, vsync, r, g, b, underflow}, {~HPOL, ~VPOL, 4'b0000});
        repeat (cycles) @(negedge clk);
        check("rst_hold", {x, y, hsync, vsync, r, g, b, underflow},
              {{(2*CW){1'b0}}, ~HPOL, ~VPOL, 4'b0000});
        rst = 1'b0;
        en = 1'b0;
        model_reset();
    endtask

    // Monitor: sample stage-0 mid-cycle, stage-1 just after the edge
    initial begin
        comb_t cs;
        exp_t  ex;
        forever begin
            @(negedge clk);
            #2;
            cs = {pix_req, x, y, line_start, frame_start};
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                ex = q.pop_front();
                popped++;
                check("stage0", cs, ex.c);
                check("stage1", {hsync, vsync, r, g, b, underflow}, ex.r);
            end
        end
    end

    initial begin
        rst = 1'b1;
        en = 1'b0;
        pix_rdy = 1'b0;
        {pix_r, pix_g, pix_b} = 3'b000;
        underflow_clr = 1'b0;
        model_reset();
        do_reset(3);

        repeat (2 * HT * VT) step(1'b1, 1'b1, 3'b111, 1'b0);
        for (int i = 0; i < 4 * HT * VT; i++) step((i % 2) == 0, 1'b1, 3'b101, 1'b0);

        // Underflow at (5,3), then clear, then clear colliding with a new miss
        while (m_pos != 3 * HT + 5) step(1'b1, 1'b1, 3'b111, 1'b0);
        step(1'b1, 1'b0, 3'b111, 1'b0);
        step(1'b1, 1'b1, 3'b111, 1'b0);
        step(1'b1, 1'b1, 3'b111, 1'b1);
        step(1'b1, 1'b1, 3'b111, 1'b0);
        while (m_pos != 3 * HT + 5) step(1'b1, 1'b1, 3'b111, 1'b0);
        step(1'b1, 1'b0, 3'b110, 1'b1);
        step(1'b1, 1'b1, 3'b011, 1'b0);

        repeat (1500) rand_step();

        while (m_pos != 2 * HT + 6) step(1'b1, 1'b1, 3'b010, 1'b0);
        do_reset(2);
        step(1'b1, 1'b1, 3'b111, 1'b0);
        repeat (400) rand_step();

        repeat (3) @(negedge clk);
        check("drain", popped, pushed);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
